mem_stage_lsu: RTL and testbench

//  Next-generation MEM pipeline stage: a load/store unit between EX/MEM and MEM/WB.

---
 rtl/mem_stage_pkg.sv | 26 ++
 rtl/lsu_align.sv | 66 ++++++
 rtl/mem_stage_lsu.sv | 170 +++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared encodings for the MEM-stage load/store unit: access sizes, FSM states, lane masks.
package mem_stage_pkg;

    typedef logic [1:0] size_t;
    localparam size_t SZ_B = 2'd0;
    localparam size_t SZ_H = 2'd1;
    localparam size_t SZ_W = 2'd2;
    localparam size_t SZ_D = 2'd3;

    typedef logic [1:0] state_t;
    localparam state_t IDLE     = 2'd0;
    localparam state_t REQ      = 2'd1;
    localparam state_t WAIT_RSP = 2'd2;
    localparam state_t RETIRE   = 2'd3;

    // Byte-offset bits that must be zero for an access of this size to be aligned.
    function automatic logic [2:0] size_lane_mask(input size_t sz);
        case (sz)
            SZ_B:    return 3'd0;
            SZ_H:    return 3'd1;
            SZ_W:    return 3'd3;
            default: return 3'd7;
        endcase
    endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane handling: store data replication and byte strobes, load extract and extend.
module lsu_align
    import mem_stage_pkg::*;
#(
    parameter int unsigned WORD_BITWIDTH = 32,
    parameter int unsigned LANE_BITS     = $clog2(WORD_BITWIDTH / 8)
) (
    input  size_t                      st_size,
    input  logic [LANE_BITS-1:0]       st_lane,
    input  logic [WORD_BITWIDTH-1:0]   st_data,
    output logic [WORD_BITWIDTH-1:0]   wdata,
    output logic [WORD_BITWIDTH/8-1:0] wstrb,
    input  size_t                      ld_size,
    input  logic                       ld_unsigned,
    input  logic [LANE_BITS-1:0]       ld_lane,
    input  logic [WORD_BITWIDTH-1:0]   ld_data,
    output logic [WORD_BITWIDTH-1:0]   ld_ext
);

    localparam int unsigned NB = WORD_BITWIDTH / 8;

    logic [NB-1:0]            mask;
    logic [WORD_BITWIDTH-1:0] shifted;

    always_comb begin
        wdata = st_data;
        mask  = '1;
        case (st_size)
            SZ_B: begin
                wdata = {NB{st_data[7:0]}};
                mask  = NB'(1);
            end
            SZ_H: begin
                wdata = {(NB / 2){st_data[15:0]}};
                mask  = NB'(3);
            end
            SZ_W: begin
                wdata = {(NB / 4){st_data[31:0]}};
                mask  = NB'(15);
            end
            default: ;
        endcase
        wstrb = mask << st_lane;
    end

    always_comb begin
        shifted = ld_data >> {ld_lane, 3'b000};
        ld_ext  = shifted;
        case (ld_size)
            SZ_B: begin
                if (ld_unsigned) ld_ext = WORD_BITWIDTH'(shifted[7:0]);
                else             ld_ext = WORD_BITWIDTH'($signed(shifted[7:0]));
            end
            SZ_H: begin
                if (ld_unsigned) ld_ext = WORD_BITWIDTH'(shifted[15:0]);
                else             ld_ext = WORD_BITWIDTH'($signed(shifted[15:0]));
            end
            SZ_W: begin
                if (ld_unsigned) ld_ext = WORD_BITWIDTH'(shifted[31:0]);
                else             ld_ext = WORD_BITWIDTH'($signed(shifted[31:0]));
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// MEM pipeline stage load/store unit with valid/ready memory request and variable-latency response.
// Optional MEM_STAGE_MISALIGN_TRAP_EN: misaligned accesses retire with misalign=1 and no request.
module mem_stage_lsu
    import mem_stage_pkg::*;
#(
    parameter int unsigned WORD_BITWIDTH    = 32,
    parameter int unsigned REG_NUM_BITWIDTH = 5,
    parameter int unsigned LANE_BITS        = $clog2(WORD_BITWIDTH / 8)
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [WORD_BITWIDTH-1:0]    ALUresult,
    input  logic [WORD_BITWIDTH-1:0]    regReadData2,
    input  logic                        memRead,
    input  logic                        memWrite,
    input  logic                        memToReg,
    input  logic [2:0]                  funct3,
    input  logic [REG_NUM_BITWIDTH-1:0] rd,
    output logic                        mem_req_valid,
    input  logic                        mem_req_ready,
    output logic                        mem_we,
    output logic [WORD_BITWIDTH-1:0]    mem_addr,
    output logic [WORD_BITWIDTH-1:0]    mem_wdata,
    output logic [WORD_BITWIDTH/8-1:0]  mem_wstrb,
    input  logic                        mem_rsp_valid,
    input  logic [WORD_BITWIDTH-1:0]    mem_rdata,
    output logic                        out_valid,
    output logic [REG_NUM_BITWIDTH-1:0] out_rd,
    output logic [WORD_BITWIDTH-1:0]    regWriteData,
    output logic                        stall
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    ,
    output logic                        misalign
`endif
);

    localparam int unsigned NB = WORD_BITWIDTH / 8;

    state_t                      state;
    size_t                       size_in;
    size_t                       size_q;
    logic [2:0]                  lane_mask3;
    logic [LANE_BITS-1:0]        align_mask;
    logic [LANE_BITS-1:0]        lane_in;
    logic [LANE_BITS-1:0]        lane_eff;
    logic [LANE_BITS-1:0]        lane_q;
    logic                        is_mem;
    logic                        go_mem;
    logic                        uns_q;
    logic                        mtr_q;
    logic                        we_q;
    logic [WORD_BITWIDTH-1:0]    addr_q;
    logic [WORD_BITWIDTH-1:0]    wdata_q;
    logic [NB-1:0]               wstrb_q;
    logic [WORD_BITWIDTH-1:0]    result_q;
    logic [REG_NUM_BITWIDTH-1:0] rd_q;
    logic [WORD_BITWIDTH-1:0]    st_wdata;
    logic [NB-1:0]               st_wstrb;
    logic [WORD_BITWIDTH-1:0]    ld_ext;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic                        misaligned;
    logic                        misalign_q;
`endif

    always_comb begin
        size_in = size_t'(funct3[1:0]);
        // A 32-bit datapath has no double access; treat it as a word.
        if (WORD_BITWIDTH == 32 && size_in == SZ_D) size_in = SZ_W;
        lane_mask3 = size_lane_mask(size_in);
        align_mask = lane_mask3[LANE_BITS-1:0];
        lane_in    = ALUresult[LANE_BITS-1:0];
        is_mem     = memRead | memWrite;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        misaligned = is_mem && ((lane_in & align_mask) != '0);
        lane_eff   = lane_in;
        go_mem     = is_mem && !misaligned;
`else
        lane_eff   = lane_in & ~align_mask;
        go_mem     = is_mem;
`endif
    end

    lsu_align #(
        .WORD_BITWIDTH(WORD_BITWIDTH),
        .LANE_BITS    (LANE_BITS)
    ) u_align (
        .st_size    (size_in),
        .st_lane    (lane_eff),
        .st_data    (regReadData2),
        .wdata      (st_wdata),
        .wstrb      (st_wstrb),
        .ld_size    (size_q),
        .ld_unsigned(uns_q),
        .ld_lane    (lane_q),
        .ld_data    (mem_rdata),
        .ld_ext     (ld_ext)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            size_q   <= SZ_B;
            lane_q   <= '0;
            uns_q    <= 1'b0;
            mtr_q    <= 1'b0;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            wstrb_q  <= '0;
            result_q <= '0;
            rd_q     <= '0;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
            misalign_q <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        rd_q     <= rd;
                        result_q <= ALUresult;
                        size_q   <= size_in;
                        lane_q   <= lane_eff;
                        uns_q    <= funct3[2];
                        mtr_q    <= memToReg;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
                        misalign_q <= misaligned;
                        if (misaligned) result_q <= '0;
`endif
                        if (go_mem) begin
                            state   <= REQ;
                            we_q    <= memWrite;
                            addr_q  <= {ALUresult[WORD_BITWIDTH-1:LANE_BITS], {LANE_BITS{1'b0}}};
                            wdata_q <= memWrite ? st_wdata : '0;
                            wstrb_q <= memWrite ? st_wstrb : '0;
                        end else begin
                            state <= RETIRE;
                        end
                    end
                end
                REQ: begin
                    if (mem_req_ready) state <= we_q ? RETIRE : WAIT_RSP;
                end
                WAIT_RSP: begin
                    if (mem_rsp_valid) begin
                        state <= RETIRE;
                        if (mtr_q) result_q <= ld_ext;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign in_ready      = (state == IDLE);
    assign mem_req_valid = (state == REQ);
    assign out_valid     = (state == RETIRE);
    assign stall         = in_valid & ~in_ready;
    assign mem_we        = we_q;
    assign mem_addr      = addr_q;
    assign mem_wdata     = wdata_q;
    assign mem_wstrb     = wstrb_q;
    assign out_rd        = rd_q;
    assign regWriteData  = result_q;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    assign misalign      = out_valid & misalign_q;
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed self-checking bench for mem_stage_lsu (32-bit datapath).
module tb_mem_stage_lsu;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] ALUresult;
    logic [31:0] regReadData2;
    logic        memRead;
    logic        memWrite;
    logic        memToReg;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        mem_req_valid;
    logic        mem_req_ready;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_rsp_valid;
    logic [31:0] mem_rdata;
    logic        out_valid;
    logic [4:0]  out_rd;
    logic [31:0] regWriteData;
    logic        stall;
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    int n_checks = 0;
    int n_errors = 0;
    int ov_cnt   = 0;
    int ov_base;

    always #5 clk = ~clk;

    always @(posedge clk) if (out_valid) ov_cnt++;

    mem_stage_lsu dut (
        .clk          (clk),
        .reset        (reset),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .ALUresult    (ALUresult),
        .regReadData2 (regReadData2),
        .memRead      (memRead),
        .memWrite     (memWrite),
        .memToReg     (memToReg),
        .funct3       (funct3),
        .rd           (rd),
        .mem_req_valid(mem_req_valid),
        .mem_req_ready(mem_req_ready),
        .mem_we       (mem_we),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rsp_valid(mem_rsp_valid),
        .mem_rdata    (mem_rdata),
        .out_valid    (out_valid),
        .out_rd       (out_rd),
        .regWriteData (regWriteData),
        .stall        (stall)
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        ,
        .misalign     (misalign)
`endif
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic [31:0] addr, input logic [31:0] sdata, input logic rdn,
                         input logic wrn, input logic mtr, input logic [2:0] f3,
                         input logic [4:0] dst);
        in_valid     = 1'b1;
        ALUresult    = addr;
        regReadData2 = sdata;
        memRead      = rdn;
        memWrite     = wrn;
        memToReg     = mtr;
        funct3       = f3;
        rd           = dst;
    endtask

    // Store with immediate request acceptance; called and returns on a falling edge.
    task automatic do_store(input string tag, input logic [31:0] addr, input logic [31:0] sdata,
                            input logic [2:0] f3, input logic [31:0] e_addr,
                            input logic [31:0] e_wdata, input logic [3:0] e_wstrb);
        drive(addr, sdata, 1'b0, 1'b1, 1'b0, f3, 5'd9);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_req"}, 64'(mem_req_valid), 64'd1);
        chk({tag, "_we"}, 64'(mem_we), 64'd1);
        chk({tag, "_addr"}, 64'(mem_addr), 64'(e_addr));
        chk({tag, "_wdata"}, 64'(mem_wdata), 64'(e_wdata));
        chk({tag, "_wstrb"}, 64'(mem_wstrb), 64'(e_wstrb));
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk({tag, "_ov"}, 64'(out_valid), 64'd1);
        chk({tag, "_req_done"}, 64'(mem_req_valid), 64'd0);
        @(negedge clk);
    endtask

    task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] f3,
                           input logic [31:0] rdata, input logic [31:0] e_addr,
                           input logic [31:0] e_data);
        drive(addr, 32'h0, 1'b1, 1'b0, 1'b1, f3, 5'd7);
        @(negedge clk);
        in_valid = 1'b0;
        chk({tag, "_req"}, 64'(mem_req_valid), 64'd1);
        chk({tag, "_addr"}, 64'(mem_addr), 64'(e_addr));
        chk({tag, "_wstrb"}, 64'(mem_wstrb), 64'd0);
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b1;
        mem_rdata     = rdata;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk({tag, "_ov"}, 64'(out_valid), 64'd1);
        chk({tag, "_rd"}, 64'(out_rd), 64'd7);
        chk({tag, "_data"}, 64'(regWriteData), 64'(e_data));
        @(negedge clk);
    endtask

    initial begin
        reset         = 1'b1;
        in_valid      = 1'b0;
        ALUresult     = '0;
        regReadData2  = '0;
        memRead       = 1'b0;
        memWrite      = 1'b0;
        memToReg      = 1'b0;
        funct3        = '0;
        rd            = '0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rdata     = '0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // Reset state
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_req", 64'(mem_req_valid), 64'd0);
        chk("rst_we", 64'(mem_we), 64'd0);
        chk("rst_ov", 64'(out_valid), 64'd0);
        chk("rst_addr", 64'(mem_addr), 64'd0);
        chk("rst_wdata", 64'(mem_wdata), 64'd0);
        chk("rst_wstrb", 64'(mem_wstrb), 64'd0);
        chk("rst_rwd", 64'(regWriteData), 64'd0);
        chk("rst_out_rd", 64'(out_rd), 64'd0);

        // Stores
        do_store("sb", 32'h103, 32'hAABBCCDD, 3'd0, 32'h100, 32'hDDDDDDDD, 4'b1000);
        do_store("sh", 32'h102, 32'h1234ABCD, 3'd1, 32'h100, 32'hABCDABCD, 4'b1100);
        do_store("sw", 32'h208, 32'h01020304, 3'd2, 32'h208, 32'h01020304, 4'b1111);

        // Loads with extension
        do_load("lh", 32'h202, 3'd1, 32'h80011234, 32'h200, 32'hFFFF8001);
        do_load("lhu", 32'h202, 3'd5, 32'h80011234, 32'h200, 32'h00008001);
        do_load("lb", 32'h201, 3'd0, 32'h00008000, 32'h200, 32'hFFFFFF80);
        do_load("lbu", 32'h203, 3'd4, 32'h7F000000, 32'h200, 32'h0000007F);

        // LW: request held 3 cycles, response 2 cycles after acceptance
        ov_base = ov_cnt;
        drive(32'h300, 32'h0, 1'b1, 1'b0, 1'b1, 3'd2, 5'd12);
        chk("lw_stall_idle", 64'(stall), 64'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("lw_stall_req", 64'(stall), 64'd1);
            chk("lw_req_hold", 64'(mem_req_valid), 64'd1);
            chk("lw_addr_hold", 64'(mem_addr), 64'h300);
            chk("lw_no_ov", 64'(out_valid), 64'd0);
        end
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        chk("lw_stall_wait", 64'(stall), 64'd1);
        chk("lw_req_gone", 64'(mem_req_valid), 64'd0);
        @(negedge clk);
        chk("lw_stall_wait2", 64'(stall), 64'd1);
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'hCAFEBABE;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("lw_ov", 64'(out_valid), 64'd1);
        chk("lw_stall_ret", 64'(stall), 64'd1);
        chk("lw_data", 64'(regWriteData), 64'hCAFEBABE);
        chk("lw_rd", 64'(out_rd), 64'd12);
        in_valid = 1'b0;
        @(negedge clk);
        chk("lw_ov_once", 64'(ov_cnt - ov_base), 64'd1);

        // Non-memory op
        drive(32'h55, 32'h0, 1'b0, 1'b0, 1'b0, 3'd0, 5'd3);
        @(negedge clk);
        in_valid = 1'b0;
        chk("add_ov", 64'(out_valid), 64'd1);
        chk("add_req", 64'(mem_req_valid), 64'd0);
        chk("add_data", 64'(regWriteData), 64'h55);
        chk("add_rd", 64'(out_rd), 64'd3);
        @(negedge clk);
        chk("add_ov_end", 64'(out_valid), 64'd0);

        // Reset during WAIT_RSP, late response ignored
        ov_base = ov_cnt;
        drive(32'h400, 32'h0, 1'b1, 1'b0, 1'b1, 3'd2, 5'd4);
        @(negedge clk);
        in_valid      = 1'b0;
        mem_req_ready = 1'b1;
        @(negedge clk);
        mem_req_ready = 1'b0;
        reset         = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk("rstw_ready", 64'(in_ready), 64'd1);
        mem_rsp_valid = 1'b1;
        mem_rdata     = 32'h12345678;
        @(negedge clk);
        mem_rsp_valid = 1'b0;
        chk("rstw_ready2", 64'(in_ready), 64'd1);
        chk("rstw_rwd", 64'(regWriteData), 64'd0);
        @(negedge clk);
        chk("rstw_no_ov", 64'(ov_cnt - ov_base), 64'd0);

        // Misaligned LW at 0x102
`ifdef MEM_STAGE_MISALIGN_TRAP_EN
        drive(32'h102, 32'h0, 1'b1, 1'b0, 1'b1, 3'd2, 5'd8);
        @(negedge clk);
        in_valid = 1'b0;
        chk("mis_ov", 64'(out_valid), 64'd1);
        chk("mis_flag", 64'(misalign), 64'd1);
        chk("mis_req", 64'(mem_req_valid), 64'd0);
        chk("mis_data", 64'(regWriteData), 64'd0);
        @(negedge clk);
        chk("mis_flag_end", 64'(misalign), 64'd0);
`else
        do_load("lwmis", 32'h102, 3'd2, 32'h11223344, 32'h100, 32'h11223344);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
